load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Memory stage of the RV32I core, downstream of the ALU: takes the ALU-computed
//   address plus rs2 data, performs LB/LH/LW/LBU/LHU/SB/SH/SW against a data memory
//   with a valid/ready request channel and an rvalid response channel, and returns
//   extended load data to the register-file write-back path. Stalls PC/regfile while busy.
// PARAMETERS
//   MEM_TIMEOUT  255  cycles to wait for mem_rvalid in WAIT before error; 0 = wait forever
// PORTS
//   clk           in   1   clock, rising edge
//   reset         in   1   synchronous, active-high
//   req_valid     in   1   core presents a load/store this cycle
//   req_ready     out  1   LSU accepts request (state IDLE and reset low)
//   req_is_store  in   1   1 = store, 0 = load
//   req_funct3    in   3   RV32I funct3 (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101)
//   req_addr      in   32  byte address from ALU
//   req_wdata     in   32  store data (rs2)
//   stall         out  1   high in ISSUE/WAIT, and in IDLE when req_valid=1
//   resp_valid    out  1   one-cycle pulse: access complete
//   resp_rdata    out  32  extended load data (0 for stores); held until next resp
//   resp_err      out  1   with resp_valid: illegal funct3, timeout, or misaligned trap
//   resp_misalign out  1   with resp_valid: misaligned access (0 unless MISALIGN_TRAP_EN)
//   mem_valid     out  1   memory request valid
//   mem_ready     in   1   memory accepts request
//   mem_we        out  1   1 = write
//   mem_addr      out  32  word-aligned address {addr[31:2],2'b00}
//   mem_wstrb     out  4   byte lane enables (0000 for reads)
//   mem_wdata     out  32  lane-replicated store data
//   mem_rvalid    in   1   read data valid
//   mem_rdata     in   32  read data word
// BEHAVIOUR
//   FSM IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE. All mem_*/resp_* outputs registered.
//   IDLE: req_ready=1; on req_valid latch is_store/funct3/addr/wdata. Illegal funct3
//     (011,110,111, or 100/101 with store) or trapped misalign -> RESP, err=1, no mem access.
//   ISSUE: mem_valid=1; addr/we/wstrb/wdata stable until mem_ready=1. On handshake:
//     store -> RESP; load -> WAIT. mem_valid drops the cycle after handshake.
//   WAIT: counter from 0; mem_rvalid -> capture, extend, RESP. Counter reaching
//     MEM_TIMEOUT (nonzero) -> RESP, err=1, rdata=0. rvalid earliest cycle after handshake.
//   RESP: resp_valid=1 one cycle, req_ready=0; next state IDLE.
//   Latency (mem_ready immediate, rvalid next cycle): load req@T -> resp_valid@T+3;
//     store -> resp_valid@T+2.
//   Lanes, off=addr[1:0]: SB wstrb=0001<<off, wdata={4{b}}; SH wstrb=0011<<{off[1],1'b0},
//     wdata={2{h}}; SW wstrb=1111. Load byte=rdata[8*off+:8], half=rdata[16*off[1]+:16];
//     LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
//   mem_rvalid outside WAIT ignored (late response after timeout or reset dropped).
//   Reset (sync, any state, mid-transaction included): state IDLE, mem_valid/mem_we=0,
//     mem_addr/wstrb/wdata=0, resp_valid/err/misalign=0, resp_rdata=0, counter=0;
//     req_ready=0 and stall=0 while reset high.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 ->
//     no mem access, RESP with resp_err=1, resp_misalign=1, resp_rdata=0.
//   Undefined: no check; halfword ignores addr[0], word ignores addr[1:0] (aligned down);
//     resp_misalign tied 0.
// TESTING
//   LW addr 0x10, mem_rdata 0xDEADBEEF -> mem_addr 0x10, wstrb 0000, resp_rdata 0xDEADBEEF @T+3.
//   LB addr 0x13 / LBU addr 0x13, rdata 0x80FF0011 -> resp_rdata 0xFFFFFF80 / 0x00000080.
//   SH addr 0x22, wdata 0x1234ABCD -> wstrb 1100, mem_wdata 0xABCDABCD, mem_addr 0x20, resp @T+2.
//   mem_ready low 5 cycles in ISSUE -> mem_valid/addr held stable, stall=1 throughout.
//   MEM_TIMEOUT=4, no rvalid -> resp_err=1 after 4 WAIT cycles; later rvalid ignored.
//   LW addr 0x21: with MISALIGN_TRAP_EN -> no mem_valid, err=1, misalign=1; without -> reads 0x20.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit -- RV32I memory stage.
//
// Accepts one load/store at a time from the core and runs it against a data
// memory. The memory has a valid/ready request channel and an rvalid response
// channel. Load data is sign- or zero-extended and handed to write-back.
// The PC and register file are held off through the stall output while busy.
//
// FSM: IDLE -> ISSUE -> (WAIT, loads only) -> RESP -> IDLE.
// Illegal or trapped requests go straight from IDLE to RESP with no memory access.
//
// Parameters
//   MEM_TIMEOUT  number of WAIT cycles before a load is abandoned with
//                resp_err; 0 means wait forever.
// Build option
//   MISALIGN_TRAP_EN  when defined, these accesses trap instead of touching memory:
//                     misaligned LH/LHU/SH/LW/SW.
//                     When undefined, halfword/word addresses are silently aligned
//                     down and resp_misalign stays 0.
//
// Ports
//   clk, reset                      clock (rising edge), synchronous active-high reset
//   req_valid/req_ready             request handshake from the core
//   req_is_store/req_funct3         access kind (RV32I funct3 encoding)
//   req_addr/req_wdata              byte address, store data (rs2)
//   stall                           hold PC/regfile
//   resp_valid/resp_rdata           completion pulse, extended load data (held)
//   resp_err/resp_misalign          error qualifiers, valid with resp_valid
//   mem_valid/mem_ready             memory request handshake
//   mem_we/mem_addr/mem_wstrb/
//   mem_wdata                       word-aligned request, byte lanes, replicated data
//   mem_rvalid/mem_rdata            memory read response
module load_store_unit #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_misalign,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] cnt_q, cnt_d;

    logic        mem_valid_q, mem_valid_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        resp_mis_q, resp_mis_d;

    // ---------------------------------------------------------------
    // Request decode (evaluated on the incoming request in IDLE)
    // ---------------------------------------------------------------
    logic        f3_illegal;
    logic        req_mis;
    logic [3:0]  req_strb;
    logic [31:0] req_wrep;

    always_comb begin
        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_illegal = 1'b0;
            3'b100, 3'b101:         f3_illegal = req_is_store;  // no unsigned stores
            default:                f3_illegal = 1'b1;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // funct3[1:0] is the size code for every legal encoding (01 half, 10 word).
    assign req_mis = !f3_illegal &&
                     ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00));
`else
    assign req_mis = 1'b0;
`endif

    // Store data is replicated into every lane; wstrb selects the live bytes.
    always_comb begin
        unique case (req_funct3[1:0])
            2'b00: begin
                req_strb = 4'b0001 << req_addr[1:0];
                req_wrep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_strb = 4'b0011 << {req_addr[1], 1'b0};
                req_wrep = {2{req_wdata[15:0]}};
            end
            default: begin
                req_strb = 4'b1111;
                req_wrep = req_wdata;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Load data extraction (uses the latched offset and funct3)
    // ---------------------------------------------------------------
    logic [31:0] rd_shb, rd_shh, ld_ext;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign rd_shb = mem_rdata >> {off_q, 3'b000};
    assign rd_shh = mem_rdata >> {off_q[1], 4'b0000};
    assign ld_b   = rd_shb[7:0];
    assign ld_h   = rd_shh[15:0];

    always_comb begin
        unique case (funct3_q)
            3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_ext = {24'h0, ld_b};
            3'b101:  ld_ext = {16'h0, ld_h};
            default: ld_ext = mem_rdata;
        endcase
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        resp_mis_d   = resp_mis_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    is_store_d = req_is_store;
                    funct3_d   = req_funct3;
                    off_d      = req_addr[1:0];
                    if (f3_illegal || req_mis) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_mis_d   = req_mis;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d     = S_ISSUE;
                        mem_valid_d = 1'b1;
                        mem_we_d    = req_is_store;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wstrb_d = req_is_store ? req_strb : 4'b0000;
                        mem_wdata_d = req_is_store ? req_wrep : 32'h0;
                    end
                end
            end
            S_ISSUE: begin
                // Request fields stay frozen until the memory takes them.
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    if (is_store_q) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_mis_d   = 1'b0;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 32'h0;
                    end
                end
            end
            S_WAIT: begin
                // Data arriving on the last allowed cycle still wins over timeout.
                if (mem_rvalid) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_mis_d   = 1'b0;
                    resp_rdata_d = ld_ext;
                end else if (MEM_TIMEOUT != 0 && cnt_q == MEM_TIMEOUT - 1) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_mis_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 32'h1;
                end
            end
            default: begin  // S_RESP
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            cnt_q        <= 32'h0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wstrb_q  <= 4'h0;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            resp_mis_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            resp_mis_q   <= resp_mis_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign req_ready = (state_q == S_IDLE) && !reset;
    assign stall     = !reset && ((state_q == S_ISSUE) || (state_q == S_WAIT) ||
                                  (state_q == S_IDLE && req_valid));

    assign mem_valid     = mem_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wstrb     = mem_wstrb_q;
    assign mem_wdata     = mem_wdata_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign resp_misalign = resp_mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (MEM_TIMEOUT = 4).
// Each vector is one request; the bench plays the memory and records what the LSU did.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, resp_err, resp_misalign;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_misalign(resp_misalign),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        string       name;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        int          rdly;   // cycles mem_ready held low
        int          rvdly;  // cycles after handshake before rvalid (-1 = never)
        logic        mem;    // memory access expected
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata, e_rdata;
        logic        e_err, e_mis;
        int          e_lat;  // cycles from request to resp_valid
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    int          o_lat;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic [3:0]  o_strb;
    logic        o_err, o_mis, o_mv, o_we, o_stall_bad, o_unstable;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(string n, logic st, logic [2:0] f3, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] rd, int rdly, int rvdly,
                                logic mem, logic [31:0] ea, logic [3:0] es,
                                logic [31:0] ewd, logic [31:0] erd, logic ee, logic em,
                                int lat);
        vec_t v;
        v.name = n; v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.rdly = rdly; v.rvdly = rvdly; v.mem = mem; v.e_addr = ea; v.e_strb = es;
        v.e_wdata = ewd; v.e_rdata = erd; v.e_err = ee; v.e_mis = em; v.e_lat = lat;
        return v;
    endfunction

    // Issue one request and act as memory until resp_valid or 40 cycles.
    task automatic txn(input vec_t v);
        int hs;
        int waitcnt;
        hs = -1; waitcnt = 0;
        o_lat = -1; o_mv = 0; o_stall_bad = 0; o_unstable = 0;
        o_rdata = 'x; o_err = 'x; o_mis = 'x;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = v.st; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        if (!stall || !req_ready) o_stall_bad = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
            #1;
            if (resp_valid) begin
                o_lat = c; o_rdata = resp_rdata; o_err = resp_err; o_mis = resp_misalign;
                if (stall || req_ready) o_stall_bad = 1'b1;
                break;
            end
            if (!stall) o_stall_bad = 1'b1;
            if (mem_valid) begin
                if (!o_mv) begin
                    o_addr = mem_addr; o_strb = mem_wstrb; o_wdata = mem_wdata; o_we = mem_we;
                end else if (mem_addr !== o_addr || mem_wstrb !== o_strb ||
                             mem_wdata !== o_wdata || mem_we !== o_we) begin
                    o_unstable = 1'b1;
                end
                o_mv = 1'b1;
                if (waitcnt == v.rdly) begin
                    mem_ready = 1'b1; hs = c;
                end else begin
                    waitcnt++;
                end
            end
            if (hs >= 0 && v.rvdly >= 0 && c == hs + 1 + v.rvdly) begin
                mem_rvalid = 1'b1; mem_rdata = v.rdata;
            end
        end
    endtask

    vec_t vt[$];

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        //      name      st f3      addr      wdata         rdata         rdly rv mem e_addr    strb     e_wdata       e_rdata       err mis lat
        vt.push_back(mk("lw",     0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0, 1, 32'h10, 4'b0000, 32'h0,        32'hDEADBEEF, 0, 0, 3));
        vt.push_back(mk("lb",     0, 3'b000, 32'h13, 32'h0,        32'h80FF0011, 0, 0, 1, 32'h10, 4'b0000, 32'h0,        32'hFFFFFF80, 0, 0, 3));
        vt.push_back(mk("lbu",    0, 3'b100, 32'h13, 32'h0,        32'h80FF0011, 0, 0, 1, 32'h10, 4'b0000, 32'h0,        32'h00000080, 0, 0, 3));
        vt.push_back(mk("lb_b2",  0, 3'b000, 32'h12, 32'h0,        32'h80FF0011, 0, 0, 1, 32'h10, 4'b0000, 32'h0,        32'hFFFFFFFF, 0, 0, 3));
        vt.push_back(mk("lb_b0",  0, 3'b000, 32'h10, 32'h0,        32'h80FF0011, 0, 0, 1, 32'h10, 4'b0000, 32'h0,        32'h00000011, 0, 0, 3));
        vt.push_back(mk("lh_hi",  0, 3'b001, 32'h12, 32'h0,        32'h80017FFF, 0, 0, 1, 32'h10, 4'b0000, 32'h0,        32'hFFFF8001, 0, 0, 3));
        vt.push_back(mk("lhu_hi", 0, 3'b101, 32'h12, 32'h0,        32'h80017FFF, 0, 0, 1, 32'h10, 4'b0000, 32'h0,        32'h00008001, 0, 0, 3));
        vt.push_back(mk("lh_lo",  0, 3'b001, 32'h10, 32'h0,        32'h80017FFF, 0, 0, 1, 32'h10, 4'b0000, 32'h0,        32'h00007FFF, 0, 0, 3));
        vt.push_back(mk("sh",     1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0,       0,-1, 1, 32'h20, 4'b1100, 32'hABCDABCD, 32'h0,        0, 0, 2));
        vt.push_back(mk("sb1",    1, 3'b000, 32'h05, 32'h000000A5, 32'h0,       0,-1, 1, 32'h04, 4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0, 2));
        vt.push_back(mk("sb3",    1, 3'b000, 32'h0B, 32'h12345677, 32'h0,       0,-1, 1, 32'h08, 4'b1000, 32'h77777777, 32'h0,        0, 0, 2));
        vt.push_back(mk("sw",     1, 3'b010, 32'h08, 32'hCAFEF00D, 32'h0,       0,-1, 1, 32'h08, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 0, 2));
        vt.push_back(mk("bad011", 0, 3'b011, 32'h30, 32'h0,        32'h0,       0, 0, 0, 32'h0,  4'b0000, 32'h0,        32'h0,        1, 0, 1));
        vt.push_back(mk("bad_sbu",1, 3'b100, 32'h30, 32'h55,       32'h0,       0, 0, 0, 32'h0,  4'b0000, 32'h0,        32'h0,        1, 0, 1));
        vt.push_back(mk("bad110", 0, 3'b110, 32'h30, 32'h0,        32'h0,       0, 0, 0, 32'h0,  4'b0000, 32'h0,        32'h0,        1, 0, 1));
        vt.push_back(mk("lw_rdy5",0, 3'b010, 32'h40, 32'h0,        32'h13579BDF, 5, 0, 1, 32'h40, 4'b0000, 32'h0,        32'h13579BDF, 0, 0, 8));
        vt.push_back(mk("lw_late",0, 3'b010, 32'h44, 32'h0,        32'h2468ACE0, 0, 3, 1, 32'h44, 4'b0000, 32'h0,        32'h2468ACE0, 0, 0, 6));
`ifdef MISALIGN_TRAP_EN
        vt.push_back(mk("lw_mis", 0, 3'b010, 32'h21, 32'h0,        32'h11223344, 0, 0, 0, 32'h0,  4'b0000, 32'h0,        32'h0,        1, 1, 1));
        vt.push_back(mk("sh_mis", 1, 3'b001, 32'h23, 32'h0000BEEF, 32'h0,       0,-1, 0, 32'h0,  4'b0000, 32'h0,        32'h0,        1, 1, 1));
        vt.push_back(mk("lhu_mis",0, 3'b101, 32'h11, 32'h0,        32'h80017FFF, 0, 0, 0, 32'h0,  4'b0000, 32'h0,        32'h0,        1, 1, 1));
`else
        vt.push_back(mk("lw_mis", 0, 3'b010, 32'h21, 32'h0,        32'h11223344, 0, 0, 1, 32'h20, 4'b0000, 32'h0,        32'h11223344, 0, 0, 3));
        vt.push_back(mk("sh_mis", 1, 3'b001, 32'h23, 32'h0000BEEF, 32'h0,       0,-1, 1, 32'h20, 4'b1100, 32'hBEEFBEEF, 32'h0,        0, 0, 2));
        vt.push_back(mk("lhu_mis",0, 3'b101, 32'h11, 32'h0,        32'h80017FFF, 0, 0, 1, 32'h10, 4'b0000, 32'h0,        32'h00007FFF, 0, 0, 3));
`endif
        // Keep last: the late-rvalid sequence below follows this timeout.
        vt.push_back(mk("lw_tmo", 0, 3'b010, 32'h48, 32'h0,        32'h0,       0,-1, 1, 32'h48, 4'b0000, 32'h0,        32'h0,        1, 0, 6));

        // Reset: a request is ignored while reset is high.
        req_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_mem_valid", 32'(mem_valid), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk); #1;
        chk("idle_req_ready", 32'(req_ready), 32'h1);
        chk("idle_stall", 32'(stall), 32'h0);

        foreach (vt[i]) begin
            txn(vt[i]);
            chk({vt[i].name, "_lat"}, 32'(o_lat), 32'(vt[i].e_lat));
            chk({vt[i].name, "_rdata"}, o_rdata, vt[i].e_rdata);
            chk({vt[i].name, "_err"}, 32'(o_err), 32'(vt[i].e_err));
            chk({vt[i].name, "_mis"}, 32'(o_mis), 32'(vt[i].e_mis));
            chk({vt[i].name, "_memvalid"}, 32'(o_mv), 32'(vt[i].mem));
            chk({vt[i].name, "_stall"}, 32'(o_stall_bad), 32'h0);
            if (vt[i].mem) begin
                chk({vt[i].name, "_addr"}, o_addr, vt[i].e_addr);
                chk({vt[i].name, "_wstrb"}, 32'(o_strb), 32'(vt[i].e_strb));
                chk({vt[i].name, "_we"}, 32'(o_we), 32'(vt[i].st));
                chk({vt[i].name, "_stable"}, 32'(o_unstable), 32'h0);
                if (vt[i].st) chk({vt[i].name, "_wdata"}, o_wdata, vt[i].e_wdata);
            end
            // resp_valid is a single pulse; data holds afterwards.
            @(negedge clk); #1;
            chk({vt[i].name, "_pulse"}, 32'(resp_valid), 32'h0);
            chk({vt[i].name, "_hold"}, resp_rdata, vt[i].e_rdata);
        end

        // Late rvalid after the timeout must be ignored.
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk); mem_rvalid = 1'b0; #1;
        chk("late_rvalid_resp", 32'(resp_valid), 32'h0);
        chk("late_rvalid_ready", 32'(req_ready), 32'h1);
        chk("late_rvalid_rdata", resp_rdata, 32'h0);

        // Reset in the middle of an ISSUE.
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h50;
        mem_ready = 1'b0;
        @(negedge clk); #1;
        chk("mid_issue_mem_valid", 32'(mem_valid), 32'h1);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("mid_rst_mem_valid", 32'(mem_valid), 32'h0);
        chk("mid_rst_mem_addr", mem_addr, 32'h0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_stall", 32'(stall), 32'h0);
        reset = 1'b0; req_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk); mem_rvalid = 1'b0; #1;
        chk("post_rst_resp", 32'(resp_valid), 32'h0);
        chk("post_rst_ready", 32'(req_ready), 32'h1);

        // Recovery: a normal load works afterwards.
        txn(vt[0]);
        chk("recover_lat", 32'(o_lat), 32'd3);
        chk("recover_rdata", o_rdata, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
